id_pipe_stage: RTL

Registered, flow-controlled decode stage for the RV32I pipeline; successor to the purely combinational decoder. Sits between the fetch output and the EX stage. Accepts `{pc, ir}` via valid/ready, decodes at the input, and holds results in a 2-entry buffer (head + skid) so that `in_ready` is a register. Adds flush, load-use bubble insertion, illegal-instruction flagging and parametrised data/PC width.

---
 rtl/rv_decode_pkg.sv | 52 +++++
 rtl/rv_decoder.sv | 125 ++++++++++++
 rtl/id_pipe_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode types: opcodes, immediate kinds and the decoded entry held by the ID stage.
package rv_decode_pkg;

    // Storage widths; the top slices these down to its XLEN / PC_W.
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned PC_W_MAX = 64;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [11:0] MEPC_ADDR = 12'h341;
    localparam logic [31:0] MRET_IR   = 32'h30200073;

    typedef enum logic [2:0] {
        ImmI, ImmB, ImmS, ImmU, ImmJ, ImmShamt, ImmCsr, ImmDefault
    } imm_type_e;

    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [11:0]         csr_addr;
        logic [XLEN_MAX-1:0] imm;
        logic                wr_reg_n;
        logic                wr_csr_n;
        logic                is_mret;
        logic                illegal;
        logic                uses_rs1;
        logic                uses_rs2;
    } entry_t;

    function automatic entry_t entry_reset();
        entry_t e;
        e          = '0;
        e.wr_reg_n = 1'b1;
        e.wr_csr_n = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder producing one stage entry from a fetched {pc, ir}.
module rv_decoder
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          CSR_EN = 1'b1
) (
    input  logic [PC_W_MAX-1:0] pc,
    input  logic [31:0]         ir,
    output entry_t              entry
);

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic                known_op;
    logic                wr_reg;
    logic                is_csr;
    logic                sys_bad;
    logic                illegal;
    logic                is_mret;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                csr_en;
    imm_type_e           imm_type;
    logic [XLEN_MAX-1:0] imm;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign rd     = ir[11:7];
    assign csr_en = CSR_EN;

    always_comb begin
        imm_type = ImmDefault;
        known_op = 1'b1;
        wr_reg   = 1'b0;
        is_csr   = 1'b0;
        sys_bad  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm_type = ImmU;
                wr_reg   = 1'b1;
            end
            OPC_JAL: begin
                imm_type = ImmJ;
                wr_reg   = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                imm_type = ImmI;
                wr_reg   = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = ImmB;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_STORE: begin
                imm_type = ImmS;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_type = (funct3[1:0] == 2'b01) ? ImmShamt : ImmI;
                wr_reg   = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                wr_reg   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_SYSTEM: begin
                // funct3=000 is ecall/ebreak/mret/wfi; 100 is unassigned.
                sys_bad = (funct3 == 3'b100);
                if (funct3 != 3'b000 && funct3 != 3'b100) begin
                    is_csr   = 1'b1;
                    imm_type = ImmCsr;
                    wr_reg   = 1'b1;
                    uses_rs1 = ~funct3[2];
                end
            end
            default: known_op = 1'b0;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (imm_type)
            ImmI:       imm = {{52{ir[31]}}, ir[31:20]};
            ImmS:       imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            ImmB:       imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            ImmU:       imm = {{32{ir[31]}}, ir[31:12], 12'b0};
            ImmJ:       imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            ImmShamt:   imm = {58'b0, (XLEN == 64) ? ir[25] : 1'b0, ir[24:20]};
            ImmCsr:     imm = {59'b0, ir[19:15]};
            ImmDefault: imm = '0;
        endcase
    end

    assign is_mret = (ir == MRET_IR);
    assign illegal = (ir[1:0] != 2'b11) | ~known_op | sys_bad | (is_csr & ~csr_en);

    always_comb begin
        entry          = '0;
        entry.pc       = pc;
        entry.rs1      = ir[19:15];
        entry.rs2      = ir[24:20];
        entry.rd       = rd;
        entry.opcode   = opcode;
        entry.funct3   = funct3;
        entry.funct7   = ir[31:25];
        entry.csr_addr = is_mret ? MEPC_ADDR : ((is_csr & csr_en) ? ir[31:20] : 12'h000);
        entry.imm      = imm;
        entry.wr_reg_n = ~(wr_reg & (rd != 5'd0) & ~illegal);
        entry.wr_csr_n = ~(is_csr & csr_en & ~illegal);
        entry.is_mret  = is_mret;
        entry.illegal  = illegal;
        entry.uses_rs1 = uses_rs1;
        entry.uses_rs2 = uses_rs2;
    end

endmodule

// File: rtl/id_pipe_stage.sv
// Registered decode stage: head + skid buffer with registered in_ready, flush and load-use bubble.
module id_pipe_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PC_W   = 32,
    parameter bit          CSR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_ir,
    input  logic            flush,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [11:0]     out_csr_addr,
    output logic [XLEN-1:0] out_imm,
    output logic            out_wr_reg_n,
    output logic            out_wr_csr_n,
    output logic            out_is_mret,
    output logic            out_illegal
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StHead = 2'd1, StFull = 2'd2} occ_e;

    occ_e   state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t dec_entry;
    logic   in_ready_q;
    logic   push, pop, hazard;
    logic   unused_wide;

    rv_decoder #(
        .XLEN   (XLEN),
        .CSR_EN (CSR_EN)
    ) u_decoder (
        .pc    (PC_W_MAX'(in_pc)),
        .ir    (in_ir),
        .entry (dec_entry)
    );

    // Load-use check looks only at the head; the skid entry waits behind it anyway.
    assign hazard = ex_load_valid & (ex_rd != 5'd0) &
                    ((head_q.uses_rs1 & (head_q.rs1 == ex_rd)) |
                     (head_q.uses_rs2 & (head_q.rs2 == ex_rd)));

    assign push      = in_valid & in_ready_q;
    assign out_valid = (state_q != StEmpty) & ~hazard;
    assign pop       = out_valid & out_ready;
    assign in_ready  = in_ready_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StHead;
                        head_d  = dec_entry;
                    end
                end
                StHead: begin
                    if (push && pop) begin
                        head_d = dec_entry;
                    end else if (push) begin
                        state_d = StFull;
                        skid_d  = dec_entry;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d = StHead;
                        head_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            head_q     <= entry_reset();
            skid_q     <= entry_reset();
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign out_pc       = head_q.pc[PC_W-1:0];
    assign out_rs1      = head_q.rs1;
    assign out_rs2      = head_q.rs2;
    assign out_rd       = head_q.rd;
    assign out_opcode   = head_q.opcode;
    assign out_funct3   = head_q.funct3;
    assign out_funct7   = head_q.funct7;
    assign out_csr_addr = head_q.csr_addr;
    assign out_imm      = head_q.imm[XLEN-1:0];
    assign out_wr_reg_n = head_q.wr_reg_n;
    assign out_wr_csr_n = head_q.wr_csr_n;
    assign out_is_mret  = head_q.is_mret;
    assign out_illegal  = head_q.illegal;

    // Upper storage bits are dead when XLEN / PC_W are below the package maxima.
    assign unused_wide = ^{head_q.pc, head_q.imm};

endmodule
